ldpc_iter_ctrl: RTL and testbench
=================================

# ldpc_iter_ctrl

Iteration scheduler for the LDPC error-correction decoder. Accepts one frame per start handshake and tells the datapath when to capture the frame. It sequences the VNPU-latch and CNPU-latch phases of each iteration and stops on syndrome convergence, on the configured iteration cap, or on abort. It sits above the VNPU/CNPU/decision datapath and replaces free-running cycle counting with a frame-level start/done protocol.

## Interface
- `ITER_CYCLES`, 7: clock cycles per decoding iteration (≥4)
- `VN_LATCH_CYC`, 2: phase index at which the VNPU output register loads
- `CN_LATCH_CYC`, 4: phase index at which the CNPU output register loads; required `VN_LATCH_CYC < CN_LATCH_CYC < ITER_CYCLES-1`
- `MAX_ITERS`, 17: default iteration cap, used when `max_iters_cfg == 0`
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  frame request; x_i/qber stable from this cycle until `done`
- `start_ready`  out  1  high only in IDLE
- `max_iters_cfg`  in  8  iteration cap, sampled on start acceptance; 0 → `MAX_ITERS`
- `abort`  in  1  terminate current frame
- `synd_valid`  in  1  decision-unit syndrome is valid this cycle
- `syndrome_zero`  in  1  all parity checks satisfied
- `load_frame`  out  1  one-cycle pulse: datapath captures x_i/qber
- `vn_latch`  out  1  one-cycle pulse: load Qij register
- `cn_latch`  out  1  one-cycle pulse: load Rji register
- `first_iter`  out  1  high while `iteration_num == 0` in RUN (datapath forces Rji input to zero)
- `iteration_num`  out  8  current iteration index
- `busy`  out  1  high in LOAD and RUN
- `done`  out  1  one-cycle termination pulse
- `converged`  out  1  frame ended on zero syndrome; held until next acceptance
- `aborted`  out  1  frame ended by abort; held until next acceptance
- `iters_used`  out  8  iterations completed at termination; held until next acceptance

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are Moore-decoded from registered state, `cycle_cnt`, and `iteration_num`, except the held result registers.
- IDLE: `start & start_ready` → LOAD. Latch `max_it` (cfg or default). Clear `converged`, `aborted`, and `iters_used`.
- LOAD: `load_frame`=1, `iteration_num`=0, `cycle_cnt`=0 → RUN.
- RUN: `cycle_cnt` counts 0..ITER_CYCLES-1.
  - `vn_latch` is high when `cycle_cnt == VN_LATCH_CYC`.
  - `cn_latch` is high when `cycle_cnt == CN_LATCH_CYC`.
- RUN, last phase (`cycle_cnt == ITER_CYCLES-1`), in priority order:
  - `synd_valid & syndrome_zero` → DONE, converged=1.
  - `iteration_num == max_it-1` → DONE, converged=0.
  - Otherwise, `iteration_num`++ and `cycle_cnt`=0.
- On entry to DONE from the last phase, `iters_used = iteration_num+1`.
- `synd_valid` in any other cycle is ignored.
- `abort` in LOAD or RUN → DONE next cycle with aborted=1 and converged=0.
  - `iters_used` = number of fully completed iterations (0 if aborted in LOAD).
  - Abort outranks convergence in the same cycle.
  - `abort` in IDLE or DONE is ignored.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` outside IDLE is ignored and not queued.
- `iteration_num` does not increment past `max_it-1`. The 8-bit width supports caps up to 255.
- Reset values: state IDLE, `start_ready`=1, and every other output 0.
- Reset mid-frame returns to IDLE in the next cycle, with no `done` pulse.

## Timing
- Start accepted at edge T: `load_frame` in cycle T+1; RUN phase 0 in cycle T+2.
- Iteration k, phase p occurs at cycle T+2+k·ITER_CYCLES+p.
- Full run of N iterations: `done` in cycle T+2+N·ITER_CYCLES. Defaults, 17 iterations: T+121.
- Earliest next acceptance is the cycle after `done`, so the minimum frame period is N·ITER_CYCLES+3.
- The decision unit must present the syndrome no later than phase ITER_CYCLES-1, using the Rji latched at CN_LATCH_CYC.

## Structure
- Package `ldpc_ctrl_pkg`:
  - FSM state enum
  - default parameter constants
  - `ITER_W` = 8
- Sub-module `ldpc_phase_counter`:
  - holds `cycle_cnt` and decodes `vn_latch`, `cn_latch`, and `last_phase`
  - has clear and enable inputs

## Test plan
- Defaults, cfg=0, syndrome never zero → 17 `vn_latch` and 17 `cn_latch` pulses; `done` at T+121; iters_used=17, converged=0.
- cfg=3; `synd_valid` & `syndrome_zero` at phase 6 of iteration 1 → `done` at T+2+14 = T+16; converged=1, iters_used=2.
- `abort` at iteration 2, phase 3 → `done` next cycle; aborted=1, iters_used=2; no further latch pulses.
- `abort` and a zero syndrome in the same last-phase cycle → aborted=1, converged=0.
- `start` held high during RUN → no second `load_frame`; after `done`, the next acceptance occurs one cycle later.
- `rst` asserted at iteration 5 → next cycle IDLE, all outputs 0, `start_ready`=1, no `done` pulse.

Source files
------------

// File: rtl/ldpc_iter_ctrl_pkg.sv
// Shared types and defaults for the LDPC iteration scheduler.
package ldpc_ctrl_pkg;
  localparam int ITER_W           = 8;
  localparam int DEF_ITER_CYCLES  = 7;
  localparam int DEF_VN_LATCH_CYC = 2;
  localparam int DEF_CN_LATCH_CYC = 4;
  localparam int DEF_MAX_ITERS    = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ldpc_iter_ctrl_if.sv
// Frame handshake, datapath strobes and result bus of the iteration scheduler.
interface ldpc_iter_ctrl_if;
  import ldpc_ctrl_pkg::*;

  logic              start;
  logic              start_ready;
  logic [ITER_W-1:0] max_iters_cfg;
  logic              abort;
  logic              synd_valid;
  logic              syndrome_zero;
  logic              load_frame;
  logic              vn_latch;
  logic              cn_latch;
  logic              first_iter;
  logic [ITER_W-1:0] iteration_num;
  logic              busy;
  logic              done;
  logic              converged;
  logic              aborted;
  logic [ITER_W-1:0] iters_used;

  modport slave (
    input  start, max_iters_cfg, abort, synd_valid, syndrome_zero,
    output start_ready, load_frame, vn_latch, cn_latch, first_iter,
           iteration_num, busy, done, converged, aborted, iters_used
  );

  modport master (
    output start, max_iters_cfg, abort, synd_valid, syndrome_zero,
    input  start_ready, load_frame, vn_latch, cn_latch, first_iter,
           iteration_num, busy, done, converged, aborted, iters_used
  );
endinterface

// File: rtl/ldpc_iter_ctrl_phase_counter.sv
// Per-iteration phase counter; wraps every ITER_CYCLES and decodes the latch strobes.
module ldpc_phase_counter
  import ldpc_ctrl_pkg::*;
#(
  parameter int ITER_CYCLES  = DEF_ITER_CYCLES,
  parameter int VN_LATCH_CYC = DEF_VN_LATCH_CYC,
  parameter int CN_LATCH_CYC = DEF_CN_LATCH_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_vn_latch,
  output logic o_cn_latch,
  output logic o_last_phase
);
  localparam int CW = cnt_width(ITER_CYCLES);
  localparam logic [CW-1:0] LAST_AT = CW'(ITER_CYCLES - 1);
  localparam logic [CW-1:0] VN_AT   = CW'(VN_LATCH_CYC);
  localparam logic [CW-1:0] CN_AT   = CW'(CN_LATCH_CYC);

  logic [CW-1:0] r_cycle_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cycle_cnt == LAST_AT);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cycle_cnt <= '0;
    end else if (i_en) begin
      r_cycle_cnt <= w_at_last ? '0 : r_cycle_cnt + CW'(1);
    end
  end

  // Strobes are qualified by enable so they never fire outside the RUN phase.
  assign o_vn_latch   = i_en && (r_cycle_cnt == VN_AT);
  assign o_cn_latch   = i_en && (r_cycle_cnt == CN_AT);
  assign o_last_phase = i_en && w_at_last;
endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Frame-level iteration scheduler: start/done handshake, per-iteration latch strobes,
// termination on zero syndrome, iteration cap or abort; result flags held until next start.
module ldpc_iter_ctrl
  import ldpc_ctrl_pkg::*;
#(
  parameter int ITER_CYCLES  = DEF_ITER_CYCLES,
  parameter int VN_LATCH_CYC = DEF_VN_LATCH_CYC,
  parameter int CN_LATCH_CYC = DEF_CN_LATCH_CYC,
  parameter int MAX_ITERS    = DEF_MAX_ITERS
) (
  input logic              clk,
  input logic              rst,
  ldpc_iter_ctrl_if.slave  io_ctrl
);
  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] r_max_it;
  logic [ITER_W-1:0] r_iters_used;
  logic              r_converged;
  logic              r_aborted;
  logic              w_run;
  logic              w_accept;
  logic              w_last;
  logic              w_vn;
  logic              w_cn;
  logic              w_conv;
  logic              w_cap;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = (r_state == ST_IDLE) && io_ctrl.start;
  assign w_conv   = w_last && io_ctrl.synd_valid && io_ctrl.syndrome_zero;
  assign w_cap    = w_last && (r_iter == r_max_it - ITER_W'(1));

  ldpc_phase_counter #(
    .ITER_CYCLES  (ITER_CYCLES),
    .VN_LATCH_CYC (VN_LATCH_CYC),
    .CN_LATCH_CYC (CN_LATCH_CYC)
  ) u_phase (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (!w_run),
    .i_en         (w_run),
    .o_vn_latch   (w_vn),
    .o_cn_latch   (w_cn),
    .o_last_phase (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = io_ctrl.abort ? ST_DONE : ST_RUN;
      ST_RUN:  if (io_ctrl.abort || w_conv || w_cap) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Abort reports only completed iterations, so the one in flight is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iter       <= '0;
      r_max_it     <= '0;
      r_iters_used <= '0;
      r_converged  <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_max_it     <= (io_ctrl.max_iters_cfg == '0) ? ITER_W'(MAX_ITERS) : io_ctrl.max_iters_cfg;
          r_iter       <= '0;
          r_iters_used <= '0;
          r_converged  <= 1'b0;
          r_aborted    <= 1'b0;
        end
        ST_LOAD: if (io_ctrl.abort) begin
          r_aborted    <= 1'b1;
          r_iters_used <= '0;
        end
        ST_RUN: begin
          if (io_ctrl.abort) begin
            r_aborted    <= 1'b1;
            r_iters_used <= r_iter;
          end else if (w_conv) begin
            r_converged  <= 1'b1;
            r_iters_used <= r_iter + ITER_W'(1);
          end else if (w_cap) begin
            r_iters_used <= r_iter + ITER_W'(1);
          end else if (w_last) begin
            r_iter <= r_iter + ITER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_ctrl.start_ready   = (r_state == ST_IDLE);
  assign io_ctrl.load_frame    = (r_state == ST_LOAD);
  assign io_ctrl.busy          = (r_state == ST_LOAD) || w_run;
  assign io_ctrl.done          = (r_state == ST_DONE);
  assign io_ctrl.vn_latch      = w_vn;
  assign io_ctrl.cn_latch      = w_cn;
  assign io_ctrl.first_iter    = w_run && (r_iter == '0);
  assign io_ctrl.iteration_num = r_iter;
  assign io_ctrl.converged     = r_converged;
  assign io_ctrl.aborted       = r_aborted;
  assign io_ctrl.iters_used    = r_iters_used;
endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Bench for ldpc_iter_ctrl: per-cycle comparison against a schedule computed from frame arithmetic.
module tb_ldpc_iter_ctrl;
  import ldpc_ctrl_pkg::*;

  localparam int IC   = 7;
  localparam int VN   = 2;
  localparam int CN   = 4;
  localparam int MAXI = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldpc_iter_ctrl_if bus ();

  ldpc_iter_ctrl #(
    .ITER_CYCLES  (IC),
    .VN_LATCH_CYC (VN),
    .CN_LATCH_CYC (CN),
    .MAX_ITERS    (MAXI)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_ctrl (bus)
  );

  int total = 0;
  int bad   = 0;
  int h_conv = 0, h_abt = 0, h_used = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.start_ready, bus.load_frame, bus.vn_latch, bus.cn_latch,
                bus.first_iter, bus.busy, bus.done});
  endfunction

  function automatic logic [31:0] results();
    return 32'({bus.converged, bus.aborted, bus.iters_used});
  endfunction

  function automatic logic [31:0] res_vec(input int c, input int a, input int u);
    return 32'({c[0], a[0], u[7:0]});
  endfunction

  // One frame. conv_it: iteration whose last phase shows a zero syndrome (-1: never).
  // Abort (when ab_en) is raised in iteration ab_it, phase ab_ph; ab_it=-1 means during LOAD.
  task automatic run_frame(input int cfg, input int conv_it, input bit ab_en,
                           input int ab_it, input int ab_ph, input bit hold);
    int max_it, end_k, done_t, ta, used, k, p;
    bit conv, abt, run;
    max_it = (cfg == 0) ? MAXI : cfg;
    conv   = (conv_it >= 0) && (conv_it < max_it);
    end_k  = conv ? conv_it : max_it - 1;
    done_t = 2 + (end_k + 1) * IC;
    used   = end_k + 1;
    abt    = 1'b0;
    ta     = -1;
    if (ab_en) begin
      ta = (ab_it < 0) ? 1 : 2 + ab_it * IC + ab_ph;
      if (ta < done_t) begin
        done_t = ta + 1;
        abt    = 1'b1;
        conv   = 1'b0;
        used   = (ab_it < 0) ? 0 : ab_it;
      end
    end

    @(negedge clk);
    check("idle_strobes", strobes(), 32'b1000000);
    check("held_results", results(), res_vec(h_conv, h_abt, h_used));
    bus.start         = 1'b1;
    bus.max_iters_cfg = cfg[7:0];
    bus.abort         = 1'($urandom_range(0, 1));
    bus.synd_valid    = 1'($urandom_range(0, 1));
    bus.syndrome_zero = 1'($urandom_range(0, 1));

    for (int t = 1; t <= done_t; t++) begin
      @(negedge clk);
      k   = (t >= 2) ? (t - 2) / IC : 0;
      p   = (t >= 2) ? (t - 2) % IC : 0;
      run = (t >= 2) && (t < done_t);
      check("strobes", strobes(),
            32'({1'b0, t == 1, run && p == VN, run && p == CN, run && k == 0, t < done_t, t == done_t}));
      if (run) check("iteration_num", 32'(bus.iteration_num), 32'(k));
      if (t == 1) check("cleared_results", results(), 32'd0);
      if (t == done_t) check("final_results", results(), res_vec(conv, abt, used));

      bus.start         = hold;
      bus.max_iters_cfg = 8'($urandom);
      bus.abort         = ab_en && (t == ta);
      if (run && p == IC - 1 && k == conv_it) begin
        bus.synd_valid    = 1'b1;
        bus.syndrome_zero = 1'b1;
      end else if (run && p == IC - 1) begin
        bus.synd_valid    = 1'($urandom_range(0, 1));
        bus.syndrome_zero = bus.synd_valid ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        bus.synd_valid    = 1'($urandom_range(0, 1));
        bus.syndrome_zero = 1'($urandom_range(0, 1));
      end
    end
    h_conv = conv;
    h_abt  = abt;
    h_used = used;
  endtask

  task automatic reset_mid(input int cfg, input int r_it);
    int tr;
    tr = 2 + r_it * IC + 1;
    @(negedge clk);
    bus.start         = 1'b1;
    bus.max_iters_cfg = cfg[7:0];
    bus.abort         = 1'b0;
    bus.synd_valid    = 1'b0;
    bus.syndrome_zero = 1'b0;
    for (int t = 1; t <= tr; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (t == tr) begin
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        check("iter_before_rst", 32'(bus.iteration_num), 32'(r_it));
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check("rst_strobes", strobes(), 32'b1000000);
    check("rst_iter", 32'(bus.iteration_num), 32'd0);
    check("rst_results", results(), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_done", strobes(), 32'b1000000);
    end
    h_conv = 0;
    h_abt  = 0;
    h_used = 0;
  endtask

  initial begin
    int cfg, cv, ai, ap;
    bit ae, hd;
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.max_iters_cfg = '0;
    bus.abort         = 1'b0;
    bus.synd_valid    = 1'b0;
    bus.syndrome_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_strobes", strobes(), 32'b1000000);
    check("reset_iter", 32'(bus.iteration_num), 32'd0);
    check("reset_results", results(), 32'd0);
    rst = 1'b0;

    run_frame(0, -1, 1'b0, 0, 0, 1'b0);    // default cap: 17 iterations, done at T+121
    run_frame(3, 1, 1'b0, 0, 0, 1'b0);     // converge in iteration 1, done at T+16
    run_frame(5, -1, 1'b1, 2, 3, 1'b0);    // abort mid iteration 2
    run_frame(4, 1, 1'b1, 1, IC - 1, 1'b0); // abort and zero syndrome together
    run_frame(2, -1, 1'b0, 0, 0, 1'b1);    // start held through the frame
    run_frame(2, 0, 1'b0, 0, 0, 1'b0);
    run_frame(3, -1, 1'b1, -1, 0, 1'b0);   // abort during LOAD
    run_frame(1, -1, 1'b0, 0, 0, 1'b0);    // single-iteration cap
    reset_mid(8, 5);

    for (int n = 0; n < 12; n++) begin
      cfg = (n == 5) ? 0 : int'($urandom_range(1, 6));
      cv  = int'($urandom_range(0, 7)) - 1;
      ae  = 1'($urandom_range(0, 1));
      ai  = int'($urandom_range(0, 4)) - 1;
      ap  = int'($urandom_range(0, IC - 1));
      hd  = 1'($urandom_range(0, 1));
      run_frame(cfg, cv, ae, ai, ap, hd);
    end

    @(negedge clk);
    bus.start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
